// File: rtl/nand_cmd_addr_seq.sv
// Command/address latch sequencer for one half NAND package: turns CLE/ALE byte
// requests into timed CE#/CLE/ALE/WE#/DQ waveforms for the IOB flop stage.
module nand_cmd_addr_seq #(
   parameter int CENS_PER_IO = 2,
   parameter int T_SETUP     = 2,
   parameter int T_WP        = 2,
   parameter int T_WH        = 2,
   parameter int CE_W        = (CENS_PER_IO > 1) ? $clog2(CENS_PER_IO) : 1
) (
   input  logic                   clk0,
   input  logic                   rst0_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_is_addr,
   input  logic [7:0]             req_data,
   input  logic [CE_W-1:0]        req_ce_idx,
   input  logic                   req_last,
   input  logic                   wp_n_req,
   output logic                   ctrl_cle,
   output logic                   ctrl_ale,
   output logic                   ctrl_wrn,
   output logic                   ctrl_wpn,
   output logic [CENS_PER_IO-1:0] ctrl_cen,
   output logic [7:0]             dq_out,
   output logic                   dq_oe,
   output logic                   busy
);

   // state    | meaning
   // ---------+--------------------------------------------------------------
   // S_IDLE   | no latch cycle; CE# holds, request accepted here
   // S_CE_SWAP| one cycle with every CE# high before moving to a new CE
   // S_SETUP  | CE#/CLE/ALE/DQ valid, WE# high for T_SETUP cycles
   // S_WE_LOW | WE# low for T_WP cycles
   // S_WE_HIGH| WE# high, CLE/ALE/DQ held for T_WH cycles

   localparam int T_MAX_SW = (T_SETUP > T_WP) ? T_SETUP : T_WP;
   localparam int T_MAX    = (T_MAX_SW > T_WH) ? T_MAX_SW : T_WH;
   localparam int CNT_W    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LD_WP    = CNT_W'(T_WP - 1);
   localparam logic [CNT_W-1:0] LD_WH    = CNT_W'(T_WH - 1);
   localparam logic [CE_W:0]    NUM_CE   = (CE_W + 1)'(CENS_PER_IO);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CE_SWAP = 3'd1,
      S_SETUP   = 3'd2,
      S_WE_LOW  = 3'd3,
      S_WE_HIGH = 3'd4
   } state_t;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_cle;
   logic                   r_ale;
   logic                   r_wrn;
   logic                   r_wpn;
   logic [CENS_PER_IO-1:0] r_cen;
   logic [7:0]             r_dq;
   logic                   r_oe;
   logic                   r_is_addr;
   logic [7:0]             r_data;
   logic [CE_W-1:0]        r_ce_idx;
   logic                   r_last;
   logic                   r_ce_held;

   logic [CENS_PER_IO-1:0] w_cen_req;
   logic [CENS_PER_IO-1:0] w_cen_cap;
   logic                   w_req_in_range;
   logic                   w_cap_in_range;
   logic                   w_accept;
   logic                   w_need_swap;

   // An out-of-range index matches no bit, so no CE# is asserted for it.
   always_comb begin
      w_cen_req = '1;
      w_cen_cap = '1;
      for (int i = 0; i < CENS_PER_IO; i++) begin
         w_cen_req[i] = (req_ce_idx != CE_W'(i));
         w_cen_cap[i] = (r_ce_idx != CE_W'(i));
      end
   end

   assign w_req_in_range = ({1'b0, req_ce_idx} < NUM_CE);
   assign w_cap_in_range = ({1'b0, r_ce_idx} < NUM_CE);
   assign w_accept       = req_valid && (r_state == S_IDLE);
   assign w_need_swap    = r_ce_held && (r_ce_idx != req_ce_idx);

   always_ff @(posedge clk0 or negedge rst0_n) begin
      if (!rst0_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_cle     <= 1'b0;
         r_ale     <= 1'b0;
         r_wrn     <= 1'b1;
         r_wpn     <= 1'b0;
         r_cen     <= '1;
         r_dq      <= 8'h00;
         r_oe      <= 1'b0;
         r_is_addr <= 1'b0;
         r_data    <= 8'h00;
         r_ce_idx  <= '0;
         r_last    <= 1'b0;
         r_ce_held <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_wpn <= wp_n_req;
               r_wrn <= 1'b1;
               r_cle <= 1'b0;
               r_ale <= 1'b0;
               r_oe  <= 1'b0;
               if (w_accept) begin
                  r_is_addr <= req_is_addr;
                  r_data    <= req_data;
                  r_ce_idx  <= req_ce_idx;
                  r_last    <= req_last;
                  if (w_need_swap) begin
                     r_state   <= S_CE_SWAP;
                     r_cen     <= '1;
                     r_ce_held <= 1'b0;
                  end else begin
                     r_state   <= S_SETUP;
                     r_cnt     <= LD_SETUP;
                     r_cen     <= w_cen_req;
                     r_ce_held <= w_req_in_range;
                     r_cle     <= !req_is_addr;
                     r_ale     <= req_is_addr;
                     r_dq      <= req_data;
                     r_oe      <= 1'b1;
                  end
               end
            end
            S_CE_SWAP: begin
               r_state   <= S_SETUP;
               r_cnt     <= LD_SETUP;
               r_cen     <= w_cen_cap;
               r_ce_held <= w_cap_in_range;
               r_cle     <= !r_is_addr;
               r_ale     <= r_is_addr;
               r_dq      <= r_data;
               r_oe      <= 1'b1;
            end
            S_SETUP: begin
               if (r_cnt == '0) begin
                  r_state <= S_WE_LOW;
                  r_cnt   <= LD_WP;
                  r_wrn   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WE_LOW: begin
               if (r_cnt == '0) begin
                  r_state <= S_WE_HIGH;
                  r_cnt   <= LD_WH;
                  r_wrn   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WE_HIGH: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_cle   <= 1'b0;
                  r_ale   <= 1'b0;
                  r_oe    <= 1'b0;
                  if (r_last) begin
                     r_cen     <= '1;
                     r_ce_held <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_wrn   <= 1'b1;
               r_cen   <= '1;
            end
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign ctrl_cle  = r_cle;
   assign ctrl_ale  = r_ale;
   assign ctrl_wrn  = r_wrn;
   assign ctrl_wpn  = r_wpn;
   assign ctrl_cen  = r_cen;
   assign dq_out    = r_dq;
   assign dq_oe     = r_oe;
   assign busy      = (r_state != S_IDLE) || !(&r_cen);

   a_ce_idx_range: assert property (@(posedge clk0) disable iff (!rst0_n)
      (req_valid && req_ready) |-> ({1'b0, req_ce_idx} < NUM_CE));

   a_one_ce_low: assert property (@(posedge clk0) disable iff (!rst0_n)
      ($countones(~ctrl_cen) <= 1));

   a_ce_stable_we_low: assert property (@(posedge clk0) disable iff (!rst0_n)
      !ctrl_wrn |=> $stable(ctrl_cen));

endmodule

// File: tb/tb_nand_cmd_addr_seq.sv
// Scoreboard bench for nand_cmd_addr_seq: each accepted byte pushes its expected
// per-cycle pin waveform, a negedge monitor pops and compares cycle by cycle.
module tb_nand_cmd_addr_seq;
   localparam int CENS = 2;
   localparam int TS   = 2;
   localparam int TWP  = 2;
   localparam int TWH  = 2;
   localparam int CEW  = 1;
   localparam int JEND = TS + TWP + TWH;

   logic           clk0 = 1'b0;
   logic           rst0_n = 1'b0;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_is_addr = 1'b0;
   logic [7:0]     req_data = 8'h00;
   logic [CEW-1:0] req_ce_idx = '0;
   logic           req_last = 1'b0;
   logic           wp_n_req = 1'b1;
   logic           ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_wpn, dq_oe, busy;
   logic [CENS-1:0] ctrl_cen;
   logic [7:0]     dq_out;

   nand_cmd_addr_seq #(.CENS_PER_IO(CENS), .T_SETUP(TS), .T_WP(TWP), .T_WH(TWH)) dut (
      .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_is_addr(req_is_addr), .req_data(req_data), .req_ce_idx(req_ce_idx),
      .req_last(req_last), .wp_n_req(wp_n_req), .ctrl_cle(ctrl_cle), .ctrl_ale(ctrl_ale),
      .ctrl_wrn(ctrl_wrn), .ctrl_wpn(ctrl_wpn), .ctrl_cen(ctrl_cen), .dq_out(dq_out),
      .dq_oe(dq_oe), .busy(busy));

   always #5 clk0 = ~clk0;

   typedef struct {
      int          cyc;
      logic [16:0] v;
   } exp_t;

   exp_t       sb[$];
   int         cyc_cnt = 0;
   int         n_checks = 0;
   int         n_errors = 0;
   logic       m_held = 1'b0;
   int         m_idx = 0;
   logic [7:0] m_prev_dq = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] pins();
      return {req_ready, busy, ctrl_wpn, ctrl_cle, ctrl_ale, ctrl_wrn, ctrl_cen, dq_oe, dq_out};
   endfunction

   always @(posedge clk0) cyc_cnt <= cyc_cnt + 1;

   always @(negedge clk0) begin : monitor
      exp_t e;
      if (rst0_n) begin
         while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            e = sb.pop_front();
            chk($sformatf("pins_cyc%0d", e.cyc), 32'(pins()), 32'(e.v));
         end
         chk("cen_one_low", 32'($countones(~ctrl_cen) <= 1), 32'd1);
      end
   end

   task automatic issue(input logic a, input logic [7:0] d, input int idx, input logic last);
      int          n;
      int          sw;
      int          e0;
      int          j;
      logic [1:0]  sel;
      logic [16:0] v;
      exp_t        e;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk0);
         n++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      sw  = (m_held && m_idx != idx) ? 1 : 0;
      e0  = cyc_cnt + 1;
      sel = 2'b11;
      sel[idx] = 1'b0;
      req_valid   = 1'b1;
      req_is_addr = a;
      req_data    = d;
      req_ce_idx  = CEW'(idx);
      req_last    = last;
      for (int k = 0; k <= JEND + sw; k++) begin
         j = k - sw;
         if (j < 0)
            v = {1'b0, 1'b1, wp_n_req, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, m_prev_dq};
         else if (j < JEND)
            v = {1'b0, 1'b1, wp_n_req, !a, a, !(j >= TS && j < TS + TWP), sel, 1'b1, d};
         else
            v = {1'b1, !last, wp_n_req, 1'b0, 1'b0, 1'b1, (last ? 2'b11 : sel), 1'b0, d};
         e.cyc = e0 + k;
         e.v   = v;
         sb.push_back(e);
      end
      m_prev_dq = d;
      m_held    = !last;
      m_idx     = idx;
      @(posedge clk0);
      @(negedge clk0);
      req_valid   = 1'b0;
      req_data    = 8'($urandom);
      req_is_addr = !a;
      req_last    = !last;
      req_ce_idx  = ~CEW'(idx);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk0);
         n++;
      end
      if (sb.size() > 0) begin
         chk("idle_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      // reset values, with wp_n_req high to show WP# resets low regardless
      #12;
      chk("rst_pins", 32'({ctrl_cen, ctrl_wrn, ctrl_cle, ctrl_ale, ctrl_wpn, dq_oe, dq_out}),
          32'({2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
      @(negedge clk0);
      rst0_n = 1'b1;
      @(negedge clk0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("wpn_idle", 32'(ctrl_wpn), 32'd1);

      // single command byte
      issue(1'b0, 8'hFF, 0, 1'b1);
      wait_idle();

      // command + five address bytes on CE1
      issue(1'b0, 8'h00, 1, 1'b0);
      issue(1'b1, 8'h11, 1, 1'b0);
      issue(1'b1, 8'h22, 1, 1'b0);
      issue(1'b1, 8'h33, 1, 1'b0);
      issue(1'b1, 8'h44, 1, 1'b0);
      issue(1'b1, 8'h55, 1, 1'b1);
      wait_idle();

      // CE swap: CE0 held, then CE1
      issue(1'b0, 8'h70, 0, 1'b0);
      issue(1'b0, 8'h90, 1, 1'b1);
      wait_idle();

      // WP# toggled while WE# is low must wait for IDLE
      issue(1'b0, 8'h60, 0, 1'b1);
      @(negedge clk0);
      @(negedge clk0);
      wp_n_req = 1'b0;
      wait_idle();
      @(negedge clk0);
      chk("wpn_follow", 32'(ctrl_wpn), 32'd0);

      // async reset during WE# low
      issue(1'b1, 8'hA5, 1, 1'b0);
      @(negedge clk0);
      @(negedge clk0);
      #2;
      sb.delete();
      rst0_n = 1'b0;
      #1;
      chk("midrst_wrn", 32'(ctrl_wrn), 32'd1);
      chk("midrst_cen", 32'(ctrl_cen), 32'b11);
      chk("midrst_oe", 32'(dq_oe), 32'd0);
      m_held    = 1'b0;
      m_prev_dq = 8'h00;
      @(negedge clk0);
      rst0_n = 1'b1;
      @(negedge clk0);
      chk("postrst_ready", 32'(req_ready), 32'd1);
      issue(1'b0, 8'h30, 0, 1'b1);
      issue(1'b1, 8'h12, 0, 1'b1);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
